// File: rtl/binary_to_gray_enc_if.sv
// Stream bundle for the binary-to-Gray encoder: binary input handshake and
// Gray output handshake, with adjacency flag and beat count alongside.
interface binary_to_gray_enc_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_bin;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_gray;
  logic             out_valid;
  logic             out_ready;
  logic             out_adj;
  logic [15:0]      out_cnt;

  modport master (
    output in_bin, in_valid, out_ready,
    input  in_ready, out_gray, out_valid, out_adj, out_cnt
  );

  modport slave (
    input  in_bin, in_valid, out_ready,
    output in_ready, out_gray, out_valid, out_adj, out_cnt
  );
endinterface

// File: rtl/binary_to_gray_enc.sv
// Binary-to-Gray encoder with a single-register output stage, a flag marking
// beats whose Gray code is one bit away from the previous beat, and a beat count.
module binary_to_gray_enc #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  binary_to_gray_enc_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
  logic             has_prev_q, has_prev_d;
  logic             adj_q, adj_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             accept;
  logic [WIDTH-1:0] gray_in;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic single_bit_diff(input logic [WIDTH-1:0] d);
    return ($countones(d) == 1);
  endfunction

  assign bus.in_ready  = !rst && ((state_q == EMPTY) || bus.out_ready);
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_gray  = gray_q;
  assign bus.out_adj   = adj_q;
  assign bus.out_cnt   = cnt_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign gray_in = to_gray(bus.in_bin);

  always_comb begin
    state_d     = state_q;
    gray_d      = gray_q;
    prev_gray_d = prev_gray_q;
    has_prev_d  = has_prev_q;
    adj_d       = adj_q;
    cnt_d       = cnt_q;

    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)             state_d = FULL;
        else if (bus.out_ready) state_d = EMPTY;
      end
    endcase

    if (accept) begin
      gray_d      = gray_in;
      adj_d       = has_prev_q && single_bit_diff(gray_in ^ prev_gray_q);
      cnt_d       = cnt_q + 16'd1;
      prev_gray_d = gray_in;
      has_prev_d  = 1'b1;
    end
  end

  // Output stage register; reset also clears data so outputs are never X.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      gray_q      <= '0;
      prev_gray_q <= '0;
      has_prev_q  <= 1'b0;
      adj_q       <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      gray_q      <= gray_d;
      prev_gray_q <= prev_gray_d;
      has_prev_q  <= has_prev_d;
      adj_q       <= adj_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_binary_to_gray_enc.sv
// Directed bench for binary_to_gray_enc: a behavioural reference checked every
// cycle, plus literal expectations for the named scenarios.
module tb_binary_to_gray_enc;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  binary_to_gray_enc_if #(.WIDTH(W)) bus ();

  binary_to_gray_enc #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic          m_valid = 1'b0;
  logic [W-1:0]  m_gray  = '0;
  logic          m_adj   = 1'b0;
  logic [15:0]   m_cnt   = '0;
  logic [W-1:0]  m_prev  = '0;
  logic          m_has   = 1'b0;

  function automatic int bits_set(input logic [W-1:0] v);
    int n = 0;
    for (int k = 0; k < W; k++) if (v[k]) n++;
    return n;
  endfunction

  function automatic logic model_ready();
    return !rst && (!m_valid || bus.out_ready);
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] g;
    if (rst) begin
      m_valid <= 1'b0; m_gray <= '0; m_adj <= 1'b0;
      m_cnt <= '0; m_prev <= '0; m_has <= 1'b0;
    end else if (bus.in_valid && model_ready()) begin
      g = bus.in_bin ^ {1'b0, bus.in_bin[W-1:1]};
      m_valid <= 1'b1;
      m_gray  <= g;
      m_adj   <= m_has && (bits_set(g ^ m_prev) == 1);
      m_cnt   <= m_cnt + 16'd1;
      m_prev  <= g;
      m_has   <= 1'b1;
    end else if (bus.out_ready) begin
      m_valid <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {31'b0, bus.in_ready}, {31'b0, model_ready()});
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
      if (m_valid) begin
        chk("model_gray", {24'b0, bus.out_gray}, {24'b0, m_gray});
        chk("model_adj", {31'b0, bus.out_adj}, {31'b0, m_adj});
        chk("model_cnt", {16'b0, bus.out_cnt}, {16'b0, m_cnt});
      end else begin
        chk("defined_outputs",
            {31'b0, $isunknown({bus.out_gray, bus.out_adj, bus.out_cnt})}, 32'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic [W-1:0] v, input logic vld, input logic ordy);
    #1;
    bus.in_bin    = v;
    bus.in_valid  = vld;
    bus.out_ready = ordy;
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    cyc();
    #1;
    rst = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [W-1:0] g, input logic a, input logic [15:0] c);
    chk({nm, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
    chk({nm, "_gray"}, {24'b0, bus.out_gray}, {24'b0, g});
    chk({nm, "_adj"}, {31'b0, bus.out_adj}, {31'b0, a});
    chk({nm, "_cnt"}, {16'b0, bus.out_cnt}, {16'b0, c});
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] gtbl [16];
    gtbl = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04,
             8'h0C, 8'h0D, 8'h0F, 8'h0E, 8'h0A, 8'h0B, 8'h09, 8'h08};

    bus.in_bin = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_gray", {24'b0, bus.out_gray}, 32'd0);
    chk("rst_adj", {31'b0, bus.out_adj}, 32'd0);
    chk("rst_cnt", {16'b0, bus.out_cnt}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk_en = 1'b1;
    #1 rst = 1'b0;

    // Back-to-back sequence 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      set_in(W'(i), 1'b1, 1'b1);
      cyc();
      lit("seq", gtbl[i], (i != 0), 16'(i + 1));
    end
    set_in('0, 1'b0, 1'b1);
    cyc();

    // Backpressure
    do_reset();
    set_in(8'h05, 1'b1, 1'b0);
    cyc();
    set_in(8'h06, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_gray", {24'b0, bus.out_gray}, 32'h07);
      chk("bp_hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("bp_hold_cnt", {16'b0, bus.out_cnt}, 32'd1);
      if (i < 2) cyc();
    end
    #1 bus.out_ready = 1'b1;
    #1 chk("bp_release_in_ready", {31'b0, bus.in_ready}, 32'd1);
    cyc();
    lit("bp", 8'h05, 1'b1, 16'd2);
    set_in('0, 1'b0, 1'b1);
    cyc();

    // Non-adjacent, wrap and repeat
    do_reset();
    set_in(8'h00, 1'b1, 1'b1); cyc(); lit("na0", 8'h00, 1'b0, 16'd1);
    set_in(8'h05, 1'b1, 1'b1); cyc(); lit("na5", 8'h07, 1'b0, 16'd2);
    set_in(8'hFF, 1'b1, 1'b1); cyc(); lit("naFF", 8'h80, 1'b0, 16'd3);
    set_in(8'h00, 1'b1, 1'b1); cyc(); lit("na00", 8'h00, 1'b1, 16'd4);
    set_in(8'h3C, 1'b1, 1'b1); cyc(); lit("rep1", 8'h22, 1'b0, 16'd5);
    set_in(8'h3C, 1'b1, 1'b1); cyc(); lit("rep2", 8'h22, 1'b0, 16'd6);

    // Reset while FULL and stalled; in_valid held high through reset
    set_in(8'h11, 1'b1, 1'b0); cyc();
    set_in(8'h33, 1'b1, 1'b0); cyc();
    #1 rst = 1'b1;
    cyc();
    chk("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mid_rst_cnt", {16'b0, bus.out_cnt}, 32'd0);
    #1 rst = 1'b0;
    set_in(8'h01, 1'b1, 1'b1); cyc();
    lit("post_rst", 8'h01, 1'b0, 16'd1);
    set_in('0, 1'b0, 1'b1); cyc();

    // Beat counter wrap
    do_reset();
    for (int n = 1; n <= 65536; n++) begin
      set_in(W'(n), 1'b1, 1'b1);
      cyc();
      if (n == 1)     chk("wrap_first_cnt", {16'b0, bus.out_cnt}, 32'h0001);
      if (n == 65535) chk("wrap_ffff_cnt", {16'b0, bus.out_cnt}, 32'hFFFF);
      if (n == 65536) chk("wrap_zero_cnt", {16'b0, bus.out_cnt}, 32'h0000);
    end
    set_in('0, 1'b0, 1'b1);
    cyc(); cyc();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
